// File: rtl/controle_exibicao_sequencia_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : controle_exibicao_sequencia_pkg
//  Description : State codes of the show-sequence controller and their
//                mapping to the 4-bit code shown on the 7-segment debug digit.
//  Revision    : 1.0 - initial release
// ============================================================================
package controle_exibicao_sequencia_pkg;

    localparam int c_LARGURA_ESTADO = 4;
    localparam int c_LARGURA_LEDS   = 4;

    // Codes 5..15 are unused; the FSM sends any of them back to INICIAL.
    typedef enum logic [c_LARGURA_ESTADO-1:0] {
        INICIAL = 4'd0,
        CARREGA = 4'd1,
        ACESO   = 4'd2,
        APAGADO = 4'd3,
        FIM     = 4'd4
    } estado_t;

    // The debug digit shows the raw state code, so estado7seg decodes 0..4.
    function automatic logic [c_LARGURA_ESTADO-1:0] codigo_debug(input estado_t estado);
        return estado;
    endfunction

endpackage
`default_nettype wire

// File: rtl/controle_exibicao_sequencia_if.sv
`default_nettype none
// ============================================================================
//  Module      : controle_exibicao_sequencia_if
//  Description : Bundle between the control unit / sequence memory side
//                (master) and the show-sequence controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface controle_exibicao_sequencia_if #(
    parameter int LARGURA_END = 4
);
    logic                   iniciar;
    logic                   cancelar;
    logic [LARGURA_END-1:0] limite;
    logic [3:0]             dado_memoria;
    logic [LARGURA_END-1:0] endereco;
    logic [3:0]             leds;
    logic                   exibindo;
    logic                   pronto;
    logic [3:0]             db_estado;

    modport master (
        output iniciar, cancelar, limite, dado_memoria,
        input  endereco, leds, exibindo, pronto, db_estado
    );

    modport slave (
        input  iniciar, cancelar, limite, dado_memoria,
        output endereco, leds, exibindo, pronto, db_estado
    );
endinterface
`default_nettype wire

// File: rtl/controle_exibicao_sequencia_contador_tempo.sv
`default_nettype none
// ============================================================================
//  Module      : contador_tempo
//  Description : Modulo-M cycle counter. Counts while conta is high, clears
//                on zera, flags fim while the count sits at M-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_tempo
    import controle_exibicao_sequencia_pkg::*;
#(
    parameter int M = 2
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic zera,
    input  wire logic conta,
    output logic      fim
);
    // M=1 still needs a 1-bit register; the count then never leaves 0.
    localparam int                   c_LARGURA = (M > 1) ? $clog2(M) : 1;
    localparam logic [c_LARGURA-1:0] c_ULTIMO  = c_LARGURA'(M - 1);

    logic [c_LARGURA-1:0] r_contagem;

    // Count register: clear has priority, wraps to 0 after M-1 so it never overflows.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_contagem <= '0;
        end else if (zera) begin
            r_contagem <= '0;
        end else if (conta) begin
            r_contagem <= (r_contagem == c_ULTIMO) ? '0 : r_contagem + 1'b1;
        end
    end

    assign fim = (r_contagem == c_ULTIMO);

endmodule
`default_nettype wire

// File: rtl/controle_exibicao_sequencia.sv
`default_nettype none
// ============================================================================
//  Module      : controle_exibicao_sequencia
//  Description : Show-sequence sequencer of the memory game. Walks memory
//                from address 0 to the latched round limit, lighting each
//                entry for TEMPO_ACESO cycles followed by a TEMPO_APAGADO gap,
//                then pulses pronto.
//  Revision    : 1.0 - initial release
// ============================================================================
module controle_exibicao_sequencia
    import controle_exibicao_sequencia_pkg::*;
#(
    parameter int TEMPO_ACESO   = 1000,
    parameter int TEMPO_APAGADO = 500,
    parameter int LARGURA_END   = 4
) (
    input  wire logic                    clock,
    input  wire logic                    reset,
    controle_exibicao_sequencia_if.slave bus
);

    estado_t                r_estado;
    estado_t                w_prox_estado;
    logic [LARGURA_END-1:0] r_endereco;
    logic [LARGURA_END-1:0] r_limite;
    logic [3:0]             r_leds;

    logic w_zera_aceso;
    logic w_conta_aceso;
    logic w_fim_aceso;
    logic w_zera_apagado;
    logic w_conta_apagado;
    logic w_fim_apagado;

    // The comparison precedes the increment, so the address stops at the
    // limit and never wraps even when the limit is the last address.
    logic w_ultima_entrada;
    assign w_ultima_entrada = (r_endereco == r_limite);

    contador_tempo #(.M(TEMPO_ACESO)) u_tempo_aceso (
        .clock (clock),
        .reset (reset),
        .zera  (w_zera_aceso),
        .conta (w_conta_aceso),
        .fim   (w_fim_aceso)
    );

    contador_tempo #(.M(TEMPO_APAGADO)) u_tempo_apagado (
        .clock (clock),
        .reset (reset),
        .zera  (w_zera_apagado),
        .conta (w_conta_apagado),
        .fim   (w_fim_apagado)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    // Next-state and timer control; cancelar overrides everything, iniciar included.
    always_comb begin
        w_prox_estado   = r_estado;
        w_zera_aceso    = 1'b0;
        w_conta_aceso   = 1'b0;
        w_zera_apagado  = 1'b0;
        w_conta_apagado = 1'b0;

        if (bus.cancelar) begin
            w_prox_estado  = INICIAL;
            w_zera_aceso   = 1'b1;
            w_zera_apagado = 1'b1;
        end else begin
            case (r_estado)
                INICIAL: begin
                    w_zera_aceso   = 1'b1;
                    w_zera_apagado = 1'b1;
                    if (bus.iniciar) begin
                        w_prox_estado = CARREGA;
                    end
                end
                CARREGA: begin
                    w_zera_aceso   = 1'b1;
                    w_zera_apagado = 1'b1;
                    w_prox_estado  = ACESO;
                end
                ACESO: begin
                    w_conta_aceso = 1'b1;
                    if (w_fim_aceso) begin
                        w_zera_aceso  = 1'b1;
                        w_prox_estado = APAGADO;
                    end
                end
                APAGADO: begin
                    w_conta_apagado = 1'b1;
                    if (w_fim_apagado) begin
                        w_zera_apagado = 1'b1;
                        w_prox_estado  = w_ultima_entrada ? FIM : CARREGA;
                    end
                end
                FIM: begin
                    w_prox_estado = INICIAL;
                end
                default: begin
                    w_zera_aceso   = 1'b1;
                    w_zera_apagado = 1'b1;
                    w_prox_estado  = INICIAL;
                end
            endcase
        end
    end

    // Address, latched limit and latched LED pattern.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_endereco <= '0;
            r_limite   <= '0;
            r_leds     <= '0;
        end else if (bus.cancelar) begin
            r_endereco <= '0;
            r_leds     <= '0;
        end else begin
            case (r_estado)
                INICIAL: begin
                    if (bus.iniciar) begin
                        r_endereco <= '0;
                        r_limite   <= bus.limite;
                    end
                end
                CARREGA: begin
                    r_leds <= bus.dado_memoria;
                end
                APAGADO: begin
                    if (w_fim_apagado && !w_ultima_entrada) begin
                        r_endereco <= r_endereco + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs depend only on state and registers; no input reaches them directly.
    assign bus.endereco  = r_endereco;
    assign bus.leds      = (r_estado == ACESO) ? r_leds : 4'b0000;
    assign bus.exibindo  = (r_estado != INICIAL) && (r_estado != FIM);
    assign bus.pronto    = (r_estado == FIM);
    assign bus.db_estado = codigo_debug(r_estado);

endmodule
`default_nettype wire

// File: tb/tb_controle_exibicao_sequencia.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controle_exibicao_sequencia
//  Description : Scoreboard bench for the show-sequence controller. Each run
//                pushes its expected per-cycle output trace; a monitor pops
//                and compares one entry per cycle, checking idle otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_exibicao_sequencia;
    import controle_exibicao_sequencia_pkg::*;

    localparam int TA = 3;
    localparam int TB = 2;
    localparam int LE = 4;

    typedef struct packed {
        logic [3:0] leds;
        logic [3:0] endereco;
        logic       exibindo;
        logic       pronto;
        logic [3:0] estado;
    } amostra_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [3:0] mem [16];
    amostra_t fila [$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    controle_exibicao_sequencia_if #(.LARGURA_END(LE)) bus ();

    controle_exibicao_sequencia #(
        .TEMPO_ACESO   (TA),
        .TEMPO_APAGADO (TB),
        .LARGURA_END   (LE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.dado_memoria = mem[bus.endereco];

    function automatic amostra_t mk(input int leds, input int ende, input int exib,
                                    input int pr, input int est);
        amostra_t a;
        a.leds     = 4'(leds);
        a.endereco = 4'(ende);
        a.exibindo = 1'(exib);
        a.pronto   = 1'(pr);
        a.estado   = 4'(est);
        return a;
    endfunction

    // Reference model: per entry one load cycle, TA lit cycles, TB dark
    // cycles; then one done cycle. Truncated to 'corte' cycles when a cancel hits.
    task automatic empilha(input int lim, input int corte);
        amostra_t t [$];
        for (int k = 0; k <= lim; k++) begin
            t.push_back(mk(0, k, 1, 0, 1));
            for (int i = 0; i < TA; i++) t.push_back(mk(int'(mem[k]), k, 1, 0, 2));
            for (int i = 0; i < TB; i++) t.push_back(mk(0, k, 1, 0, 3));
        end
        t.push_back(mk(0, lim, 0, 1, 4));
        if (corte > 0) while (t.size() > corte) void'(t.pop_back());
        foreach (t[i]) fila.push_back(t[i]);
    endtask

    // Monitor: one comparison per cycle, sampled on the falling edge.
    always @(negedge clock) begin
        amostra_t a;
        amostra_t e;
        a.leds     = bus.leds;
        a.endereco = bus.endereco;
        a.exibindo = bus.exibindo;
        a.pronto   = bus.pronto;
        a.estado   = bus.db_estado;
        n_vec++;
        if (fila.size() > 0) begin
            e = fila.pop_front();
            if (a !== e) begin
                n_err++;
                $display("FAIL trace t=%0t: got leds=%b end=%0d exib=%b pronto=%b est=%0d, expected leds=%b end=%0d exib=%b pronto=%b est=%0d",
                         $time, a.leds, a.endereco, a.exibindo, a.pronto, a.estado,
                         e.leds, e.endereco, e.exibindo, e.pronto, e.estado);
            end
        end else if ({a.leds, a.exibindo, a.pronto, a.estado} !== 10'd0) begin
            n_err++;
            $display("FAIL idle t=%0t: got leds=%b exib=%b pronto=%b est=%0d, expected 0000/0/0/0",
                     $time, a.leds, a.exibindo, a.pronto, a.estado);
        end
    end

    task automatic espera_fila(input int limite_ciclos);
        int n = 0;
        while (fila.size() > 0 && n < limite_ciclos) begin
            @(posedge clock);
            n++;
        end
        if (fila.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: %0d expected cycles still pending, required 0", fila.size());
            fila.delete();
        end
        repeat (3) @(posedge clock);
    endtask

    // One run; corte>0 asserts cancelar during that cycle of the run.
    task automatic execucao(input int lim, input int corte, input bit com_iniciar);
        @(negedge clock);
        bus.limite  = 4'(lim);
        bus.iniciar = 1'b1;
        @(posedge clock);
        #1;
        bus.iniciar = 1'b0;
        empilha(lim, corte);
        if (corte > 0) begin
            repeat (corte - 1) @(posedge clock);
            #1;
            bus.cancelar = 1'b1;
            bus.iniciar  = com_iniciar;
            @(posedge clock);
            #1;
            bus.cancelar = 1'b0;
            bus.iniciar  = 1'b0;
            fila.push_back(mk(0, 0, 0, 0, 0));
        end
        espera_fila(200);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lim;
        int corte;
        int n_ciclos;
        bus.iniciar  = 1'b0;
        bus.cancelar = 1'b0;
        bus.limite   = '0;
        for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
        #1 reset = 1'b0;
        #21 reset = 1'b1;
        repeat (2) @(posedge clock);

        // Short and four-entry runs with the one-hot memory.
        execucao(0, 0, 1'b0);
        execucao(3, 0, 1'b0);

        // Asynchronous reset in the middle of a lit phase.
        @(negedge clock);
        bus.limite  = 4'd3;
        bus.iniciar = 1'b1;
        @(posedge clock);
        #1;
        bus.iniciar = 1'b0;
        empilha(3, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({bus.leds, bus.endereco, bus.exibindo, bus.pronto, bus.db_estado} !== 14'd0) begin
            n_err++;
            $display("FAIL async_reset: got leds=%b end=%0d exib=%b pronto=%b est=%0d, expected all 0",
                     bus.leds, bus.endereco, bus.exibindo, bus.pronto, bus.db_estado);
        end
        fila.delete();
        @(negedge clock);
        #2;
        reset = 1'b1;
        repeat (3) @(posedge clock);

        // iniciar held through a whole run, limite changed mid-run.
        @(negedge clock);
        bus.limite  = 4'd3;
        bus.iniciar = 1'b1;
        @(posedge clock);
        #1;
        empilha(3, 0);
        fila.push_back(mk(0, 3, 0, 0, 0));
        empilha(1, 0);
        repeat (10) @(posedge clock);
        #1;
        bus.limite = 4'd1;
        repeat (16) @(posedge clock);
        #1;
        bus.iniciar = 1'b0;
        espera_fila(200);

        // Cancels in the gap of entry 1, one of them together with iniciar.
        execucao(3, 11, 1'b1);
        execucao(3, 12, 1'b0);

        // cancelar and iniciar together while idle: must stay idle.
        @(negedge clock);
        bus.limite   = 4'd2;
        bus.cancelar = 1'b1;
        bus.iniciar  = 1'b1;
        @(posedge clock);
        #1;
        bus.cancelar = 1'b0;
        bus.iniciar  = 1'b0;
        repeat (3) @(posedge clock);

        // Full 16-entry memory with arbitrary (not always one-hot) contents.
        for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
        execucao(15, 0, 1'b0);

        // Randomised runs, some of them cancelled at a random cycle.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
            lim      = int'($urandom_range(0, 15));
            n_ciclos = (lim + 1) * (1 + TA + TB) + 1;
            corte    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n_ciclos - 1)) : 0;
            execucao(lim, corte, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/controle_exibicao_sequencia.md
Name: controle_exibicao_sequencia

Overview:
Sequencer for the "show sequence" phase of the memory game. On a start pulse it walks the sequence memory from address 0 up to the current round limit. For each entry it lights the LEDs with the stored value for a fixed ON time, then blanks them for a fixed OFF time. It sits between the main control unit, which pulses iniciar and waits for pronto, and the datapath's sequence memory and LED outputs, replacing ad-hoc exhibition counters.

Parameters:
TEMPO_ACESO, 1000, LED ON time in clock cycles (1 s at 1 kHz); legal range ≥1.
TEMPO_APAGADO, 500, LED OFF (gap) time in clock cycles; legal range ≥1.
LARGURA_END, 4, memory address width (16 entries).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
iniciar  in  1  start request, sampled only in INICIAL.
cancelar  in  1  synchronous abort, any state.
limite  in  LARGURA_END  last address to show (current round), latched at start.
dado_memoria  in  4  one-hot LED pattern read combinationally at endereco.
endereco  out  LARGURA_END  memory read address.
leds  out  4  LED drive.
exibindo  out  1  high in every state except INICIAL and FIM.
pronto  out  1  one-cycle pulse when the whole sequence has been shown.
db_estado  out  4  current state code for the 7-seg debug display.

Behaviour:
- Reset (reset=0, async):
  - state=INICIAL, endereco=0, leds=0, limite_reg=0, timer=0.
  - exibindo=0, pronto=0.
- State codes: INICIAL=0, CARREGA=1, ACESO=2, APAGADO=3, FIM=4. Codes 5–15 are unused; if reached, go to INICIAL next cycle.
- INICIAL:
  - leds=0.
  - iniciar=1 -> CARREGA; endereco<=0; limite_reg<=limite; timer<=0.
  - Otherwise hold.
- CARREGA (1 cycle): leds_reg<=dado_memoria; timer<=0 -> ACESO.
- ACESO:
  - leds=leds_reg; timer increments each cycle.
  - At timer==TEMPO_ACESO-1 -> APAGADO, timer<=0.
  - Stays exactly TEMPO_ACESO cycles.
- APAGADO:
  - leds=0; timer increments.
  - At timer==TEMPO_APAGADO-1:
    - if endereco==limite_reg -> FIM;
    - else endereco<=endereco+1 -> CARREGA.
- FIM:
  - pronto=1 for this single cycle; leds=0.
  - endereco holds its last value.
  - -> INICIAL unconditionally.
- Timing:
  - Each entry costs 1+TEMPO_ACESO+TEMPO_APAGADO cycles.
  - pronto is high in cycle (limite+1)*(1+TEMPO_ACESO+TEMPO_APAGADO)+1, counting the cycle after the iniciar edge as cycle 1.
- limite=0 shows exactly one entry.
- limite=2^LARGURA_END-1 shows all entries. endereco never wraps, because the comparison happens before the increment.
- Busy behaviour:
  - iniciar is ignored outside INICIAL, including iniciar held high continuously.
  - A new run starts only after FIM->INICIAL, with at least one INICIAL cycle in between.
  - Changes to limite during a run have no effect (latched value used).
- cancelar=1 in any state:
  - next state INICIAL; leds=0; timer=0; endereco=0; no pronto.
  - cancelar has priority over iniciar in the same cycle.
- leds and pronto are registered or pure functions of state plus registers; no combinational path from inputs to outputs except through endereco->memory.
- dado_memoria is sampled only in CARREGA. Non-one-hot values pass through unchanged.
- Timer width is sized for max(TEMPO_ACESO, TEMPO_APAGADO); it never overflows.

Decomposition:
- Shared package: state code constants (INICIAL..FIM) and the debug code mapping, so estado7seg can decode them.
- One sub-module: contador_tempo (parameter M; inputs clock, reset, zera, conta; output fim when count==M-1). Instantiate it twice, for the ON and OFF timers, or once with a muxed limit.
- The FSM plus the address register stay in the top module.

Test Plan:
(Run with TEMPO_ACESO=3, TEMPO_APAGADO=2; memory model returns 1,2,4,8 at addresses 0..3.)
1. reset=0 mid-run (during ACESO) -> outputs immediately leds=0, endereco=0, exibindo=0, db_estado=0, without waiting for a clock.
2. limite=0, iniciar pulse -> leds=0001 for exactly 3 cycles, then 0 for 2 cycles; pronto single pulse in cycle 7; endereco stays 0.
3. limite=3 -> leds shows 0001, 0010, 0100, 1000, each for 3 cycles with 2-cycle gaps; endereco steps 0..3; pronto in cycle 25; exibindo high for cycles 1–24.
4. iniciar held high for the whole run and limite changed to 1 mid-run -> the run still shows 4 entries; exactly one pronto; the next run starts only after a cycle in INICIAL.
5. cancelar asserted in APAGADO of entry 1 (asserted together with iniciar in one case) -> INICIAL next cycle, leds=0, endereco=0, pronto never asserted.
6. limite=15 with a 16-entry memory -> 16 entries shown; endereco ends at 15 without wrapping; pronto in cycle 97.
